// File: rtl/mult_rr_scheduler_if.sv
// rtl/mult_rr_scheduler_if.sv - requester, result and counter signals of the shared multiplier
// The slave side is the scheduler; the master side holds the requesters and the result consumer.
interface mult_rr_scheduler_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic               req0_valid;
    logic [WIDTH-1:0]   req0_a;
    logic [WIDTH-1:0]   req0_b;
    logic               req0_ready;
    logic               req1_valid;
    logic [WIDTH-1:0]   req1_a;
    logic [WIDTH-1:0]   req1_b;
    logic               req1_ready;
    logic               res_valid;
    logic [2*WIDTH-1:0] res_data;
    logic               res_id;
    logic               res_ready;
    logic [CNT_W-1:0]   cnt0;
    logic [CNT_W-1:0]   cnt1;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        input  req0_ready, req1_ready, res_valid, res_data, res_id, cnt0, cnt1
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        output req0_ready, req1_ready, res_valid, res_data, res_id, cnt0, cnt1
    );
endinterface

// File: rtl/mult_rr_scheduler.sv
// rtl/mult_rr_scheduler.sv - round-robin sharing of one unsigned multiplier between two requesters
// One result slot; a new product may load on the same edge the held one is drained.
module mult_rr_scheduler #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mult_rr_scheduler_if.slave    bus
);
    localparam int PW = 2 * WIDTH;

    logic             res_valid_q, res_valid_d;
    logic [PW-1:0]    res_data_q, res_data_d;
    logic             res_id_q, res_id_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic          slot_free;
    logic          drain;
    logic          grant0;
    logic          grant1;
    logic [PW-1:0] product;

    always_comb begin
        slot_free = !res_valid_q || bus.res_ready;
        drain     = res_valid_q && bus.res_ready;
        // On a tie the port that did not win last time goes first.
        grant0    = slot_free && bus.req0_valid && (!bus.req1_valid || last_grant_q);
        grant1    = slot_free && bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        product   = grant1 ? PW'(bus.req1_a) * PW'(bus.req1_b)
                           : PW'(bus.req0_a) * PW'(bus.req0_b);
    end

    always_comb begin
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        if (drain) begin
            res_valid_d = 1'b0;
            if (res_id_q) cnt1_d = cnt1_q + CNT_W'(1);
            else          cnt0_d = cnt0_q + CNT_W'(1);
        end
        if (grant0 || grant1) begin
            res_valid_d  = 1'b1;
            res_data_d   = product;
            res_id_d     = grant1;
            last_grant_d = grant1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_id     = res_id_q;
    assign bus.cnt0       = cnt0_q;
    assign bus.cnt1       = cnt1_q;
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb/tb_mult_rr_scheduler.sv - vector table, corner sequences and random run against a reference model
module tb_mult_rr_scheduler;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    mult_rr_scheduler_if #(.WIDTH(4), .CNT_W(8)) bus ();
    mult_rr_scheduler_if #(.WIDTH(4), .CNT_W(2)) bus2 ();

    mult_rr_scheduler #(.WIDTH(4), .CNT_W(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    mult_rr_scheduler #(.WIDTH(4), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rst;
        int v0, a0, b0, v1, a1, b1, rr;
        int rdy0, rdy1;
        int rv, data, id, c0, c1;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    task automatic add(input int rst, input int v0, input int a0, input int b0,
                       input int v1, input int a1, input int b1, input int rr,
                       input int rdy0, input int rdy1, input int rv, input int data,
                       input int id, input int c0, input int c1);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.a0 = a0; v.b0 = b0; v.v1 = v1; v.a1 = a1; v.b1 = b1;
        v.rr = rr; v.rdy0 = rdy0; v.rdy1 = rdy1; v.rv = rv; v.data = data; v.id = id;
        v.c0 = c0; v.c1 = c1;
        tbl.push_back(v);
    endtask

    task automatic drive(input int v0, input int a0, input int b0,
                         input int v1, input int a1, input int b1, input int rr);
        bus.req0_valid = v0[0]; bus.req0_a = a0[3:0]; bus.req0_b = b0[3:0];
        bus.req1_valid = v1[0]; bus.req1_a = a1[3:0]; bus.req1_b = b1[3:0];
        bus.res_ready  = rr[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model state
    int m_rv, m_data, m_id, m_last;
    int m_cnt[2];
    int pend[2], pa[2], pb[2];

    initial begin
        n_pass = 0; n_total = 0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        bus2.req0_valid = 1'b0; bus2.req0_a = 4'd0; bus2.req0_b = 4'd0;
        bus2.req1_valid = 1'b0; bus2.req1_a = 4'd0; bus2.req1_b = 4'd0;
        bus2.res_ready  = 1'b1;
        tick();
        tick();
        chk("reset_res_valid", bus.res_valid, 0);
        chk("reset_res_data", bus.res_data, 0);
        chk("reset_res_id", bus.res_id, 0);
        chk("reset_cnt0", bus.cnt0, 0);
        chk("reset_cnt1", bus.cnt1, 0);
        rst_n = 1'b1;

        //  rst v0 a0 b0 v1 a1 b1 rr  r0 r1  rv data id c0 c1
        add(1,  1, 3, 5, 0, 0, 0, 1,  1, 0,  1, 15,  0, 0, 0);
        add(1,  0, 0, 0, 0, 0, 0, 1,  0, 0,  0, 15,  0, 1, 0);
        add(0,  0, 0, 0, 0, 0, 0, 1,  0, 0,  0, 0,   0, 0, 0);
        add(1,  1, 2, 7, 1,15,15, 1,  1, 0,  1, 14,  0, 0, 0);
        add(1,  1, 2, 7, 1,15,15, 1,  0, 1,  1, 225, 1, 1, 0);
        add(1,  1, 2, 7, 1,15,15, 1,  1, 0,  1, 14,  0, 1, 1);
        add(1,  1, 2, 7, 1,15,15, 1,  0, 1,  1, 225, 1, 2, 1);
        add(1,  0, 0, 0, 0, 0, 0, 1,  0, 0,  0, 225, 1, 2, 2);
        add(1,  1, 2, 7, 1,15,15, 0,  1, 0,  1, 14,  0, 2, 2);
        for (int i = 0; i < 5; i++)
            add(1, 1, 2, 7, 1,15,15, 0, 0, 0, 1, 14,  0, 2, 2);
        add(1,  1, 2, 7, 1,15,15, 1,  0, 1,  1, 225, 1, 3, 2);
        add(1,  0, 0, 0, 0, 0, 0, 1,  0, 0,  0, 225, 1, 3, 3);
        add(1,  0, 0, 0, 1, 1, 1, 1,  0, 1,  1, 1,   1, 3, 3);
        add(1,  0, 0, 0, 1, 2, 2, 1,  0, 1,  1, 4,   1, 3, 4);
        add(1,  0, 0, 0, 1, 3, 3, 1,  0, 1,  1, 9,   1, 3, 5);
        add(1,  0, 0, 0, 1, 4, 4, 1,  0, 1,  1, 16,  1, 3, 6);
        add(1,  1, 0, 9, 0, 0, 0, 1,  1, 0,  1, 0,   0, 3, 7);
        add(1,  1,15, 0, 0, 0, 0, 1,  1, 0,  1, 0,   0, 4, 7);
        add(1,  0, 0, 0, 1,15,15, 1,  0, 1,  1, 225, 1, 5, 7);
        add(1,  0, 0, 0, 0, 0, 0, 1,  0, 0,  0, 225, 1, 5, 8);

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst[0];
            drive(tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].v1, tbl[i].a1, tbl[i].b1, tbl[i].rr);
            #1;
            chk($sformatf("vec%0d_req0_ready", i), bus.req0_ready, tbl[i].rdy0);
            chk($sformatf("vec%0d_req1_ready", i), bus.req1_ready, tbl[i].rdy1);
            tick();
            chk($sformatf("vec%0d_res_valid", i), bus.res_valid, tbl[i].rv);
            chk($sformatf("vec%0d_res_data", i), bus.res_data, tbl[i].data);
            chk($sformatf("vec%0d_res_id", i), bus.res_id, tbl[i].id);
            chk($sformatf("vec%0d_cnt0", i), bus.cnt0, tbl[i].c0);
            chk($sformatf("vec%0d_cnt1", i), bus.cnt1, tbl[i].c1);
        end

        // counter wrap on the 2-bit-counter instance: drains land one edge after each accept
        bus2.req0_valid = 1'b1; bus2.req0_a = 4'd1; bus2.req0_b = 4'd3;
        tick();
        for (int k = 0; k < 5; k++) begin
            if (k == 4) bus2.req0_valid = 1'b0;
            tick();
            chk($sformatf("wrap_cnt0_%0d", k), bus2.cnt0, (k + 1) % 4);
        end

        // async reset while a result is held
        drive(1, 2, 7, 1, 15, 15, 0);
        tick();
        chk("mid_pre_res_valid", bus.res_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_res_valid", bus.res_valid, 0);
        chk("mid_async_res_data", bus.res_data, 0);
        chk("mid_async_cnt0", bus.cnt0, 0);
        chk("mid_async_cnt1", bus.cnt1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 2, 7, 1, 15, 15, 1);
        #1;
        chk("mid_tie_req0_ready", bus.req0_ready, 1);
        chk("mid_tie_req1_ready", bus.req1_ready, 0);
        tick();
        chk("mid_tie_res_id", bus.res_id, 0);
        chk("mid_tie_res_data", bus.res_data, 14);

        // random run from a fresh reset
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        m_rv = 0; m_data = 0; m_id = 0; m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0;
        pend[0] = 0; pend[1] = 0; pa[0] = 0; pa[1] = 0; pb[0] = 0; pb[1] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int rr, win, drained;
            for (int p = 0; p < 2; p++) begin
                if (pend[p] == 0 && $urandom_range(0, 9) < 6) begin
                    pend[p] = 1;
                    pa[p] = $urandom_range(0, 15);
                    pb[p] = $urandom_range(0, 15);
                end
            end
            rr = ($urandom_range(0, 3) != 0) ? 1 : 0;
            drive(pend[0], pa[0], pb[0], pend[1], pa[1], pb[1], rr);
            #1;
            win = -1;
            if (m_rv == 0 || rr == 1) begin
                if (pend[0] == 1 && pend[1] == 1) win = 1 - m_last;
                else if (pend[0] == 1)           win = 0;
                else if (pend[1] == 1)           win = 1;
            end
            chk("rnd_req0_ready", bus.req0_ready, (win == 0) ? 1 : 0);
            chk("rnd_req1_ready", bus.req1_ready, (win == 1) ? 1 : 0);
            tick();
            drained = (m_rv == 1 && rr == 1) ? 1 : 0;
            if (drained == 1) m_cnt[m_id] = (m_cnt[m_id] + 1) % 256;
            if (win >= 0) begin
                m_rv = 1; m_data = pa[win] * pb[win]; m_id = win; m_last = win;
                pend[win] = 0;
            end else if (drained == 1) begin
                m_rv = 0;
            end
            chk("rnd_res_valid", bus.res_valid, m_rv);
            chk("rnd_res_data", bus.res_data, m_data);
            chk("rnd_res_id", bus.res_id, m_id);
            chk("rnd_cnt0", bus.cnt0, m_cnt[0]);
            chk("rnd_cnt1", bus.cnt1, m_cnt[1]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
